writeback_unit: RTL

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_fifo.sv | 73 +++++++
 rtl/writeback_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared defaults and arbiter state encoding for the writeback unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

    localparam int WB_DATA_W     = 16;
    localparam int WB_ADDR_W     = 3;
    localparam int WB_FIFO_DEPTH = 2;

    // Which source wins when both have a result waiting.
    typedef enum logic [0:0] {
        PREFER_ALU = 1'b0,
        PREFER_MEM = 1'b1
    } arb_state_t;

endpackage : wb_pkg

// File: rtl/wb_fifo.sv
// Synchronous FIFO with full/empty flags, storage not reset.
// Latency: push visible at head one cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_do_push;
    logic             w_do_pop;
    logic [PTR_W-1:0] w_wr_nxt;
    logic [PTR_W-1:0] w_rd_nxt;

    assign o_full    = (r_cnt == FULL_CNT);
    assign o_empty   = (r_cnt == '0);
    assign o_pop_dat = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO may take a push alongside it.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Pointers wrap explicitly so non-power-of-two depths work.
    assign w_wr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);

    // Data storage: written on push, no reset needed since flags gate reads.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= w_wr_nxt;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule : wb_fifo

// File: rtl/writeback_unit.sv
// Merges ALU and load results into one register-file write port with a busy scoreboard.
// Latency: 2 cycles from acceptance to rf_we (buffer edge, then commit edge).
// Backpressure: per-source ready drops when that source's buffer is full or in reset.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR_W-1:0]      alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [ADDR_W-1:0]      mem_rd,
    input  logic [DATA_W-1:0]      mem_data,
    input  logic                   issue_valid,
    input  logic [ADDR_W-1:0]      issue_rd,
    output logic [(1<<ADDR_W)-1:0] busy,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_rw,
    output logic [DATA_W-1:0]      rf_bus_w
);

    localparam int ENT_W = ADDR_W + DATA_W;
    localparam int NREG  = 1 << ADDR_W;

    logic             w_alu_full;
    logic             w_alu_empty;
    logic             w_mem_full;
    logic             w_mem_empty;
    logic             w_alu_push;
    logic             w_mem_push;
    logic             w_alu_pop;
    logic             w_mem_pop;
    logic [ENT_W-1:0] w_alu_head;
    logic [ENT_W-1:0] w_mem_head;

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             w_grant_alu;
    logic             w_grant_mem;

    logic [ENT_W-1:0]  w_commit_ent;
    logic [ADDR_W-1:0] w_commit_rd;
    logic [DATA_W-1:0] w_commit_data;
    logic              w_commit;
    logic              w_commit_we;

    logic [NREG-1:0]   w_busy_set;
    logic [NREG-1:0]   w_busy_clr;
    logic [NREG-1:0]   r_busy;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_rw;
    logic [DATA_W-1:0] r_rf_bus_w;

    // Ready depends only on buffer state and reset, never on valid.
    assign alu_ready  = reset_n & ~w_alu_full;
    assign mem_ready  = reset_n & ~w_mem_full;
    assign w_alu_push = alu_valid & alu_ready;
    assign w_mem_push = mem_valid & mem_ready;

    wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .i_clk      (clock),
        .i_rst_n    (reset_n),
        .i_push     (w_alu_push),
        .i_push_dat ({alu_rd, alu_data}),
        .i_pop      (w_alu_pop),
        .o_pop_dat  (w_alu_head),
        .o_full     (w_alu_full),
        .o_empty    (w_alu_empty)
    );

    wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_mem_fifo (
        .i_clk      (clock),
        .i_rst_n    (reset_n),
        .i_push     (w_mem_push),
        .i_push_dat ({mem_rd, mem_data}),
        .i_pop      (w_mem_pop),
        .o_pop_dat  (w_mem_head),
        .o_full     (w_mem_full),
        .o_empty    (w_mem_empty)
    );

    // Arbiter state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= PREFER_ALU;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Preference flips only when both sources contend, giving round-robin under load.
    always_comb begin
        w_state_nxt = r_state;
        if (!w_alu_empty && !w_mem_empty) begin
            w_state_nxt = (r_state == PREFER_ALU) ? PREFER_MEM : PREFER_ALU;
        end
    end

    // Grant the preferred source on contention, otherwise whichever has data.
    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_mem = 1'b0;
        if (!w_alu_empty && !w_mem_empty) begin
            if (r_state == PREFER_ALU) begin
                w_grant_alu = 1'b1;
            end else begin
                w_grant_mem = 1'b1;
            end
        end else if (!w_alu_empty) begin
            w_grant_alu = 1'b1;
        end else if (!w_mem_empty) begin
            w_grant_mem = 1'b1;
        end
    end

    // A reset edge must not commit anything, so pops are gated by reset_n.
    assign w_alu_pop    = w_grant_alu & reset_n;
    assign w_mem_pop    = w_grant_mem & reset_n;
    assign w_commit     = w_alu_pop | w_mem_pop;
    assign w_commit_ent = w_grant_alu ? w_alu_head : w_mem_head;
    assign {w_commit_rd, w_commit_data} = w_commit_ent;
    // Register 0 is hardwired: its entries drain without a write.
    assign w_commit_we  = w_commit & (w_commit_rd != '0);

    // One-hot set/clear masks for the scoreboard; issues to register 0 are dropped.
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (issue_valid && (issue_rd != '0)) begin
            w_busy_set[issue_rd] = 1'b1;
        end
        if (w_commit_we) begin
            w_busy_clr[w_commit_rd] = 1'b1;
        end
    end

    // Scoreboard update: a new reservation outranks a same-edge retirement.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_busy_clr) | w_busy_set;
        end
    end

    // Registered write port; index and data hold when nothing is written.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rf_we    <= 1'b0;
            r_rf_rw    <= '0;
            r_rf_bus_w <= '0;
        end else begin
            r_rf_we <= w_commit_we;
            if (w_commit_we) begin
                r_rf_rw    <= w_commit_rd;
                r_rf_bus_w <= w_commit_data;
            end
        end
    end

    assign busy     = r_busy;
    assign rf_we    = r_rf_we;
    assign rf_rw    = r_rf_rw;
    assign rf_bus_w = r_rf_bus_w;

endmodule : writeback_unit
